// File: rtl/axi_slave_mem_if.sv
// Single-beat AXI-style bus between a master and axi_slave_mem.
// The slave modport drives the ready lines and both response channels.
interface axi_slave_mem_if;
  logic [3:0]  awid;
  logic [31:0] awadr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wrdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wrdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wrdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_slave_mem.sv
// Single-beat AXI slave memory of DEPTH words; AXI_SLAVE_ERR_EN adds SLVERR on out-of-range/bursts.
// Latency: write response 4 cycles after awvalid, read data 2 cycles after arvalid.
// Backpressure: bvalid/rvalid held until bready/rready; no new address accepted meanwhile.
module axi_slave_mem #(
  parameter int DEPTH = 16
) (
  input  logic           aclk,
  input  logic           areset,
  axi_slave_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_AACK, W_DATA, W_DACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_AACK, R_DATA} r_state_t;

  w_state_t       w_state, w_state_nx;
  r_state_t       r_state, r_state_nx;
  logic [3:0]     w_id_q, r_id_q;
  logic [AW-1:0]  w_idx_q, r_idx_q;
  logic           w_err_q, r_err_q;
  logic [31:0]    rdata_q;
  logic [31:0]    mem [DEPTH];
  logic           aw_err, ar_err;

`ifdef AXI_SLAVE_ERR_EN
  assign aw_err = (|bus.awadr[31:AW+2]) || (bus.awlen != 4'd0);
  assign ar_err = (|bus.araddr[31:AW+2]) || (bus.arlen != 4'd0);
`else
  // Upper address bits wrap and length is ignored.
  assign aw_err = 1'b0;
  assign ar_err = 1'b0;
  logic unused_cfg;
  assign unused_cfg = ^{bus.awadr[31:AW+2], bus.araddr[31:AW+2], bus.awlen, bus.arlen};
`endif

  logic unused_bus;
  assign unused_bus = ^{bus.awadr[1:0], bus.awsize, bus.awburst, bus.awlock, bus.awcache,
                        bus.awprot, bus.wid, bus.wlast, bus.araddr[1:0], bus.arsize,
                        bus.arlock, bus.arcache, bus.arprot};

  always_ff @(posedge aclk) begin
    if (areset) begin
      w_state <= W_IDLE;
      w_id_q  <= '0;
      w_idx_q <= '0;
      w_err_q <= 1'b0;
    end else begin
      w_state <= w_state_nx;
      if (w_state == W_IDLE && bus.awvalid) begin
        w_id_q  <= bus.awid;
        w_idx_q <= bus.awadr[AW+1:2];
        w_err_q <= aw_err;
      end
    end
  end

  always_comb begin
    w_state_nx  = w_state;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = '0;
    bus.bresp   = OKAY;
    case (w_state)
      W_IDLE: if (bus.awvalid) w_state_nx = W_AACK;
      W_AACK: begin
        bus.awready = 1'b1;
        w_state_nx  = W_DATA;
      end
      W_DATA: if (bus.wvalid) w_state_nx = W_DACK;
      W_DACK: begin
        bus.wready = 1'b1;
        w_state_nx = W_RESP;
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        bus.bid    = w_id_q;
        bus.bresp  = w_err_q ? SLVERR : OKAY;
        if (bus.bready) w_state_nx = W_IDLE;
      end
      default: w_state_nx = W_IDLE;
    endcase
  end

  // Commit happens in the W_DACK cycle; a read registering at the same edge sees the old word.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_state == W_DACK && !w_err_q) begin
      for (int b = 0; b < 4; b++)
        if (bus.wstrb[b]) mem[w_idx_q][8*b +: 8] <= bus.wrdata[8*b +: 8];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= R_IDLE;
      r_id_q  <= '0;
      r_idx_q <= '0;
      r_err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      r_state <= r_state_nx;
      if (r_state == R_IDLE && bus.arvalid) begin
        r_id_q  <= bus.arid;
        r_idx_q <= bus.araddr[AW+1:2];
        r_err_q <= ar_err;
      end
      if (r_state == R_AACK) rdata_q <= r_err_q ? 32'h0 : mem[r_idx_q];
    end
  end

  always_comb begin
    r_state_nx  = r_state;
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.rid     = '0;
    bus.rresp   = OKAY;
    bus.rdata   = '0;
    case (r_state)
      R_IDLE: if (bus.arvalid) r_state_nx = R_AACK;
      R_AACK: begin
        bus.arready = 1'b1;
        r_state_nx  = R_DATA;
      end
      R_DATA: begin
        bus.rvalid = 1'b1;
        bus.rlast  = 1'b1;
        bus.rid    = r_id_q;
        bus.rresp  = r_err_q ? SLVERR : OKAY;
        bus.rdata  = rdata_q;
        if (bus.rready) r_state_nx = R_IDLE;
      end
      default: r_state_nx = R_IDLE;
    endcase
  end
endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of 32-bit memory words (power of two, 2..256).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port aclk  input  1  the clock; all logic updates on its rising edge.
REQ-004 Port areset  input  1  synchronous active-high reset.
REQ-005 Write address ports: awid in 4, awadr in 32, awlen in 4, awsize in 3, awburst in 2, awlock in 2, awcache in 4, awprot in 3, awvalid in 1, awready out 1.
REQ-006 Write data ports: wid in 4, wrdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-007 Write response ports: bid out 4, bresp out 2, bvalid out 1, bready in 1.
REQ-008 Read address ports: arid in 4, araddr in 32, arlen in 4, arsize in 3, arlock in 2, arcache in 4, arprot in 3, arvalid in 1, arready out 1.
REQ-009 Read data ports: rid out 4, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.

Function
REQ-010 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0], awsize/arsize, burst, lock, cache and prot SHALL be ignored; every transaction is a single beat.
REQ-011 The write FSM SHALL have states W_IDLE, W_AACK, W_DATA, W_DACK, W_RESP.
REQ-012 W_IDLE: on awvalid=1, capture awid and awadr and go to W_AACK.
REQ-013 W_AACK: drive awready=1 for exactly one cycle, then go to W_DATA; awready SHALL be 0 in all other states, so every acceptance is a fresh rising edge.
REQ-014 W_DATA: wait for wvalid=1, then go to W_DACK.
REQ-015 W_DACK: drive wready=1 for exactly one cycle and commit the write in that cycle.
- Only byte lanes with wstrb[i]=1 are updated.
- wstrb=0 updates nothing and still gives an OKAY response.
REQ-016 W_RESP: drive bvalid=1, bid=captured awid and bresp; hold them until bready=1 is sampled, then deassert bvalid and return to W_IDLE.
REQ-017 The read FSM SHALL run independently of the write FSM, with states R_IDLE, R_AACK, R_DATA.
REQ-018 R_IDLE: on arvalid=1, capture arid and araddr and go to R_AACK.
REQ-019 R_AACK: drive arready=1 for exactly one cycle and register rdata from the memory.
REQ-020 R_DATA: drive rvalid=1, rlast=1, rid=captured arid and rresp; hold rdata stable until rready=1 is sampled, then clear rvalid and rlast and return to R_IDLE.
REQ-021 Write-to-read latency SHALL be read-before-write: a read sampled at the same edge as a write commit to the same word returns the old data.
REQ-022 rdata SHALL be 0 whenever rvalid=0.
REQ-023 Response codes SHALL be OKAY=2'b00 and SLVERR=2'b10.
REQ-024 A new address SHALL NOT be accepted on a channel until its previous response handshake completes.

Reset
REQ-025 While areset=1 at a rising edge, both FSMs SHALL go to their IDLE states and all outputs SHALL be 0: awready, wready, bvalid, bid, bresp, arready, rvalid, rlast, rid, rresp, rdata.
REQ-026 Reset SHALL clear all memory words to 0x00000000.
REQ-027 Reset asserted mid-transaction SHALL abandon the transaction without a response.
- A write whose W_DACK cycle has not yet occurred is not committed.
- A write already committed is then cleared by REQ-026.

Configuration
REQ-028 Macro AXI_SLAVE_ERR_EN: when defined, an address with any of bits [31:log2(DEPTH)+2] set, or a nonzero awlen/arlen, SHALL get bresp/rresp=SLVERR.
- Such a write is discarded.
- Such a read returns rdata=0.
REQ-029 When AXI_SLAVE_ERR_EN is undefined, upper address bits SHALL wrap modulo DEPTH, length SHALL be ignored, and all responses SHALL be OKAY.

Verification
REQ-030 Write/read: write addr 0x4, data 0xDEADBEEF, strobe 0xF, then read 0x4 -> rdata=0xDEADBEEF, rresp=OKAY, rlast=1.
REQ-031 Strobe: after REQ-030, write addr 0x4, data 0x11223344, strobe 0x5, then read -> rdata 0xDE22BE44.
REQ-032 Backpressure: hold bready=0 for 5 cycles -> bvalid stays 1 and bid stays stable; next awready pulse only after bready=1.
REQ-033 Range, with AXI_SLAVE_ERR_EN: write/read addr 0x40 (DEPTH=16) -> SLVERR, rdata=0, word 0 unchanged. Without the macro: the write lands in word 0 with OKAY.
REQ-034 Reset mid-write: assert areset in W_DATA -> awready, wready and bvalid are 0 next cycle; read 0x0 -> 0x0 with no stale response.
REQ-035 Concurrency: simultaneous write 0x8=0xA5A5A5A5 and read 0x8 at the same edge -> read returns old value 0; a subsequent read returns 0xA5A5A5A5.
